mem_arbiter: RTL

Two-requester arbiter and sequencer for the single-port data memory (256 x 8, synchronous write, one-cycle read). It sits between the memory and two masters: the core load/store path (port `core_*`) and the host port (`host_*`), which preloads data before a run and dumps it after `done`. It accepts one transaction at a time, drives the memory's write/read enables, address and data, and returns read data to the owner with a valid pulse.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_picker.sv | 31 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    CORE = 1'b0,
    HOST = 1'b1
  } owner_t;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/rr_picker.sv
// Two-way request picker. MEM_ARB_RR_EN selects round-robin tie-breaking;
// otherwise the core always wins a tie.
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic i_core_req,
  input  logic i_host_req,
  input  logic i_last_owner,
  output logic o_winner
);

  always_comb begin
    o_winner = CORE;
    if (i_core_req && i_host_req) begin
`ifdef MEM_ARB_RR_EN
      o_winner = (i_last_owner == HOST) ? CORE : HOST;
`else
      o_winner = CORE;
`endif
    end else if (i_host_req) begin
      o_winner = HOST;
    end
  end

`ifndef MEM_ARB_RR_EN
  // Fixed priority ignores history; keep the port for a uniform interface.
  logic w_unused_last;
  assign w_unused_last = i_last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Core/host arbiter and sequencer for a single-port synchronous data memory.
// Tie-breaking is round-robin when MEM_ARB_RR_EN is defined, core-first otherwise.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_core_req,
  input  logic              i_core_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [DATA_W-1:0] i_core_wdata,
  output logic              o_core_gnt,
  output logic              o_core_rvalid,
  output logic [DATA_W-1:0] o_core_rdata,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_gnt,
  output logic              o_host_rvalid,
  output logic [DATA_W-1:0] o_host_rdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  state_t            r_state;
  owner_t            r_owner;
  owner_t            r_last_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_core_gnt;
  logic              r_host_gnt;
  logic              r_core_rvalid;
  logic              r_host_rvalid;
  logic [DATA_W-1:0] r_core_rdata;
  logic [DATA_W-1:0] r_host_rdata;

  logic              w_winner;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_issue;

  rr_picker u_rr_picker (
    .i_core_req   (i_core_req),
    .i_host_req   (i_host_req),
    .i_last_owner (r_last_owner),
    .o_winner     (w_winner)
  );

  always_comb begin
    w_sel_we    = i_core_we;
    w_sel_addr  = i_core_addr;
    w_sel_wdata = i_core_wdata;
    if (w_winner == HOST) begin
      w_sel_we    = i_host_we;
      w_sel_addr  = i_host_addr;
      w_sel_wdata = i_host_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= IDLE;
      r_owner       <= CORE;
      r_last_owner  <= HOST;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_core_gnt    <= 1'b0;
      r_host_gnt    <= 1'b0;
      r_core_rvalid <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_core_rdata  <= '0;
      r_host_rdata  <= '0;
    end else begin
      r_core_gnt    <= 1'b0;
      r_host_gnt    <= 1'b0;
      r_core_rvalid <= 1'b0;
      r_host_rvalid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_core_req || i_host_req) begin
            r_owner      <= owner_t'(w_winner);
            r_last_owner <= owner_t'(w_winner);
            r_we         <= w_sel_we;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_core_gnt   <= (w_winner == CORE);
            r_host_gnt   <= (w_winner == HOST);
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= r_we ? IDLE : RESP;
        end
        RESP: begin
          // Memory read data is valid in this cycle; rvalid follows next cycle.
          if (r_owner == CORE) begin
            r_core_rdata  <= i_mem_rdata;
            r_core_rvalid <= 1'b1;
          end else begin
            r_host_rdata  <= i_mem_rdata;
            r_host_rvalid <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_issue       = (r_state == ISSUE);
  assign o_mem_we      = w_issue && r_we;
  assign o_mem_re      = w_issue && !r_we;
  assign o_mem_addr    = w_issue ? r_addr : '0;
  assign o_mem_wdata   = w_issue ? r_wdata : '0;
  assign o_busy        = (r_state != IDLE);
  assign o_core_gnt    = r_core_gnt;
  assign o_host_gnt    = r_host_gnt;
  assign o_core_rvalid = r_core_rvalid;
  assign o_host_rvalid = r_host_rvalid;
  assign o_core_rdata  = r_core_rdata;
  assign o_host_rdata  = r_host_rdata;

endmodule
